// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: camera-style RGB565 test pattern source (PCLK=CLK/2, VSYNC/HREF); define CAM_PATTERN_GEN_FRAME_CNT_EN for frame_cnt.
module cam_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] color,
  output logic        PCLK,
  output logic        CamVsync,
  output logic        CamHsync,
  output logic [7:0]  CamData,
  output logic        busy
`ifdef CAM_PATTERN_GEN_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);
  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(LINE);
  localparam int BW   = H_ACTIVE / 8;
  localparam int BPW  = BW > 1 ? $clog2(BW) : 1;
  localparam logic [2:0] IDLE = 3'd0, VSYNC = 3'd1, VBACK = 3'd2, ACTIVE = 3'd3, VFRONT = 3'd4;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic           pclk_q;
  logic [2:0]     state_q, state_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [15:0]    vcnt_q, vcnt_d;
  logic [1:0]     mode_q, mode_d;
  logic [15:0]    color_q, color_d;
  logic [2:0]     bar_q, bar_d;
  logic [BPW-1:0] bpix_q, bpix_d;
  logic [5:0]     x_q, x_d;
  logic [15:0]    lim, pix;
  logic           tick, line_end, v_end, hs, bwrap, fr_exit;
  // all state advances on the CLK edge where PCLK falls
  assign tick     = pclk_q;
  assign line_end = hcnt_q == HW'(LINE - 1);
  assign lim      = state_q == VSYNC ? 16'(V_SYNC) : state_q == VBACK ? 16'(V_BACK) :
                    state_q == ACTIVE ? 16'(V_ACTIVE) : 16'(V_FRONT);
  assign v_end    = vcnt_q == lim - 16'd1;
  assign hs       = state_q == ACTIVE && hcnt_q < HW'(2 * H_ACTIVE);
  assign bwrap    = bpix_q == BPW'(BW - 1);
  assign fr_exit  = tick && state_q == VFRONT && line_end && v_end;
  assign pix      = mode_q == 2'd1 ? {x_q[4:0], x_q, x_q[4:0]} :
                    mode_q == 2'd2 ? BARS[bar_q] : color_q;
  assign PCLK     = pclk_q;
  assign CamVsync = state_q == VSYNC;
  assign CamHsync = hs;
  assign CamData  = hs ? (hcnt_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  assign busy     = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    mode_d  = mode_q;
    color_d = color_q;
    bar_d   = bar_q;
    bpix_d  = bpix_q;
    x_d     = x_q;
    if (tick && state_q == IDLE && enable) begin
      state_d = VSYNC;
      mode_d  = mode;
      color_d = color;
    end else if (tick && state_q != IDLE) begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      if (hs && hcnt_q[0]) begin
        x_d    = x_q + 6'd1;
        bpix_d = bwrap ? '0 : bpix_q + 1'b1;
        bar_d  = bwrap ? bar_q + 3'd1 : bar_q;
      end
      if (line_end) begin
        x_d    = '0;
        bpix_d = '0;
        bar_d  = '0;
        vcnt_d = v_end ? '0 : vcnt_q + 16'd1;
      end
      if (line_end && v_end) begin
        state_d = state_q == VSYNC ? VBACK : state_q == VBACK ? ACTIVE :
                  state_q == ACTIVE ? VFRONT : enable ? VSYNC : IDLE;
        mode_d  = fr_exit && enable ? mode : mode_q;
        color_d = fr_exit && enable ? color : color_q;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pclk_q  <= 1'b0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      mode_q  <= '0;
      color_q <= '0;
      bar_q   <= '0;
      bpix_q  <= '0;
      x_q     <= '0;
    end else begin
      pclk_q  <= ~pclk_q;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      bar_q   <= bar_d;
      bpix_q  <= bpix_d;
      x_q     <= x_d;
    end
  end
`ifdef CAM_PATTERN_GEN_FRAME_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) frame_cnt <= 8'd0;
    else if (fr_exit) frame_cnt <= frame_cnt + 8'd1;
  end
`endif
endmodule

// File: doc/cam_pattern_gen.md
CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line; multiple of 8, at least 8.
REQ-002 Parameter H_BLANK, default 144: byte periods with CamHsync low after each line.
REQ-003 Parameter V_SYNC, default 3: line times with CamVsync high.
REQ-004 Parameter V_BACK, default 17: blank line times after vsync, before the first active line.
REQ-005 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-006 Parameter V_FRONT, default 10: blank line times after the last active line.
REQ-007 CLK  in  1  system clock; the only clock.
REQ-008 RST  in  1  synchronous reset, active-high.
REQ-009 enable  in  1  high = generate frames.
REQ-010 mode  in  2  pattern: 0 solid, 1 ramp, 2 colour bars, 3 reserved (treated as 0).
REQ-011 color  in  16  RGB565 value used in solid mode.
REQ-012 PCLK  out  1  pixel clock, CLK/2.
REQ-013 CamVsync  out  1  frame sync, active-high.
REQ-014 CamHsync  out  1  HREF; high while data bytes are valid.
REQ-015 CamData  out  8  RGB565 byte stream.
REQ-016 busy  out  1  high while a frame is in progress.

Function
REQ-017 PCLK shall toggle every CLK cycle when RST is low; one byte period is 2 CLK cycles.
REQ-018 CamVsync, CamHsync, CamData and busy shall update only on the CLK edge where PCLK goes 1->0, so they are stable at every PCLK rising edge.
REQ-019 Line time shall be 2*H_ACTIVE+H_BLANK byte periods; each active line shall have CamHsync high for 2*H_ACTIVE periods, then low for H_BLANK periods.
REQ-020 The FSM shall have the states IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
REQ-021 FSM transitions:
- IDLE->VSYNC when enable=1.
- VSYNC->VBACK after V_SYNC line times.
- VBACK->ACTIVE after V_BACK line times.
- ACTIVE->VFRONT after V_ACTIVE lines.
- VFRONT->VSYNC if enable=1, otherwise VFRONT->IDLE.
REQ-022 CamVsync shall be high exactly in VSYNC; busy shall be high in every state except IDLE.
REQ-023 Each pixel shall be sent as two bytes, pixel[15:8] first, then pixel[7:0].
REQ-024 CamData shall be 0 whenever CamHsync is low.
REQ-025 mode and color shall be sampled on entry to VSYNC and held for the whole frame; changes mid-frame take effect at the next frame.
REQ-026 Solid mode: every pixel = sampled color.
REQ-027 Ramp mode: pixel = {x[4:0], x[5:0], x[4:0]}, where x is the pixel index within the line; x starts at 0 each line and wraps modulo 64.
REQ-028 Bars mode: 8 equal bars of H_ACTIVE/8 pixels, in the order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-029 enable deasserted mid-frame: the current frame shall complete unchanged, then the FSM goes to IDLE.
REQ-030 In IDLE: CamVsync=0, CamHsync=0, CamData=0, busy=0, and PCLK keeps toggling.

Reset
REQ-031 When RST=1 at a CLK edge, the block shall, on the next cycle, set PCLK=0, CamVsync=0, CamHsync=0, CamData=0, busy=0 and state=IDLE, and clear all counters, regardless of its current state.
REQ-032 After RST is released, a new frame shall start only through IDLE->VSYNC.

Configuration
REQ-033 Macro CAM_PATTERN_GEN_FRAME_CNT_EN defined:
- adds output frame_cnt (8 bits, reset 0);
- frame_cnt increments by 1 at each VFRONT exit;
- frame_cnt wraps 255->0.
REQ-034 Macro undefined: the frame_cnt port and its register are absent; all other behaviour is identical.

Verification
Bench parameters: H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1. Line time = 20 byte periods = 40 CLK.
REQ-035 mode=0, color=F800, enable=1 after reset ->
- CamVsync high for 40 CLK, then low for 40 CLK;
- then 2 CamHsync pulses of 32 CLK each, bytes F8,00 repeated 8 times per line;
- frame period = 200 CLK.
REQ-036 mode=1 -> each line's bytes start 00,00, 08,21, 10,42, 18,63 ...
REQ-037 mode=2 -> each line's bytes are FF,FF, FF,E0, 07,FF, 07,E0, F8,1F, F8,00, 00,1F, 00,00.
REQ-038 enable dropped during the first active line -> the second active line and VFRONT still occur, then busy=0 and CamVsync stays 0.
REQ-039 mode changed from 0 to 2 mid-frame -> the current frame stays solid; the next frame shows bars.
REQ-040 RST pulsed mid-line -> the next cycle has all outputs 0 and state IDLE; frame_cnt (if the macro is defined) reads 0, then 1 and 2 after two completed frames.
